// File: rtl/mem_arbiter_if.sv
// Bus bundle between the SRAM arbiter, its two requesters and the SRAM pins.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
);
  // CPU requester
  logic              CPU_Req;
  logic              CPU_WE;
  logic [ADDR_W-1:0] CPU_Addr;
  logic [DATA_W-1:0] CPU_Wdata;
  logic              CPU_Ack;
  // Loader / debug requester
  logic              LDR_Req;
  logic              LDR_WE;
  logic [ADDR_W-1:0] LDR_Addr;
  logic [DATA_W-1:0] LDR_Wdata;
  logic              LDR_Ack;
  // Shared status
  logic [DATA_W-1:0] Rdata;
  logic              Busy;
  // SRAM side
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Data_to_SRAM;
  logic              Drive_En;
  logic [DATA_W-1:0] Data_from_SRAM;
  logic              Mem_CE;
  logic              Mem_UB;
  logic              Mem_LB;
  logic              Mem_OE;
  logic              Mem_WE;

  modport slave (
    input  CPU_Req, CPU_WE, CPU_Addr, CPU_Wdata,
    input  LDR_Req, LDR_WE, LDR_Addr, LDR_Wdata,
    input  Data_from_SRAM,
    output CPU_Ack, LDR_Ack, Rdata, Busy,
    output ADDR, Data_to_SRAM, Drive_En,
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  modport master (
    output CPU_Req, CPU_WE, CPU_Addr, CPU_Wdata,
    output LDR_Req, LDR_WE, LDR_Addr, LDR_Wdata,
    output Data_from_SRAM,
    input  CPU_Ack, LDR_Ack, Rdata, Busy,
    input  ADDR, Data_to_SRAM, Drive_En,
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin SRAM arbiter: CPU vs loader, fixed two-cycle access, one-cycle Ack.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
) (
  input logic        Clk,
  input logic        Reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC1 = 2'd1;
  localparam logic [1:0] ST_ACC2 = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LDR = 1'b1;

  logic [1:0]        state, state_nx;
  logic              last_grant, grant_nx;
  logic              op_we, we_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DATA_W-1:0] wdata_q, wdata_nx;
  logic [DATA_W-1:0] rdata_q;
  logic              cpu_ack_q, ldr_ack_q, busy_q;
  logic              oe_n_q, we_n_q, drive_q;
  logic              cpu_pick, ldr_pick, acc_nx;

  // Next-state decode, grant selection and request latching
  always_comb begin
    state_nx = state;
    grant_nx = last_grant;
    we_nx    = op_we;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    cpu_pick = 1'b0;
    ldr_pick = 1'b0;
    case (state)
      ST_IDLE: begin
        // On a tie the requester that did not win last time goes first
        cpu_pick = bus.CPU_Req && (!bus.LDR_Req || (last_grant == GNT_LDR));
        ldr_pick = bus.LDR_Req && !cpu_pick;
        if (cpu_pick) begin
          state_nx = ST_ACC1;
          grant_nx = GNT_CPU;
          we_nx    = bus.CPU_WE;
          addr_nx  = bus.CPU_Addr;
          wdata_nx = bus.CPU_Wdata;
        end else if (ldr_pick) begin
          state_nx = ST_ACC1;
          grant_nx = GNT_LDR;
          we_nx    = bus.LDR_WE;
          addr_nx  = bus.LDR_Addr;
          wdata_nx = bus.LDR_Wdata;
        end
      end
      ST_ACC1: state_nx = ST_ACC2;
      ST_ACC2: state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    acc_nx = (state_nx == ST_ACC1) || (state_nx == ST_ACC2);
  end

  // State, latched request and registered strobes/acks (computed from next state)
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      last_grant <= GNT_LDR;
      op_we      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cpu_ack_q  <= 1'b0;
      ldr_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      drive_q    <= 1'b0;
    end else begin
      state      <= state_nx;
      last_grant <= grant_nx;
      op_we      <= we_nx;
      addr_q     <= addr_nx;
      wdata_q    <= wdata_nx;
      cpu_ack_q  <= (state == ST_ACC2) && (last_grant == GNT_CPU);
      ldr_ack_q  <= (state == ST_ACC2) && (last_grant == GNT_LDR);
      busy_q     <= (state_nx != ST_IDLE);
      oe_n_q     <= !(acc_nx && !we_nx);
      we_n_q     <= !(acc_nx && we_nx);
      drive_q    <= acc_nx && we_nx;
      if ((state == ST_ACC2) && !op_we) begin
        rdata_q <= bus.Data_from_SRAM;
      end
    end
  end

  assign bus.CPU_Ack      = cpu_ack_q;
  assign bus.LDR_Ack      = ldr_ack_q;
  assign bus.Rdata        = rdata_q;
  assign bus.Busy         = busy_q;
  assign bus.ADDR         = addr_q;
  assign bus.Data_to_SRAM = wdata_q;
  assign bus.Drive_En     = drive_q;
  assign bus.Mem_OE       = oe_n_q;
  assign bus.Mem_WE       = we_n_q;
  assign bus.Mem_CE       = 1'b0;
  assign bus.Mem_UB       = 1'b0;
  assign bus.Mem_LB       = 1'b0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small behavioural SRAM.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;
  localparam logic WHO_CPU = 1'b0;
  localparam logic WHO_LDR = 1'b1;

  typedef struct {
    logic              who;
    logic [DATA_W-1:0] rdata;
    int                issue;
    int                lat;
    int                gap;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc       = 0;
  int   tests     = 0;
  int   fails     = 0;
  int   ack_total = 0;
  int   last_ack  = 0;
  int   oe_lo     = 0;
  int   we_lo     = 0;
  int   de_cnt    = 0;
  exp_t sb[$];
  logic [DATA_W-1:0] mem [256];

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: read data only while OE is low, write on the clock while WE is low
  assign bus.Data_from_SRAM = (!bus.Mem_OE) ? mem[bus.ADDR[7:0]] : 16'h0000;
  always @(posedge clk) begin
    if (!bus.Mem_WE && bus.Drive_En) mem[bus.ADDR[7:0]] = bus.Data_to_SRAM;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(logic who, logic [DATA_W-1:0] rd, int lat, int gap);
    exp_t e;
    e.who = who; e.rdata = rd; e.issue = cyc; e.lat = lat; e.gap = gap;
    sb.push_back(e);
  endfunction

  // Monitor: strobe invariants, strobe counters and ack-driven scoreboard pops
  always @(negedge clk) begin
    exp_t e;
    check("oe_we_exclusive", 32'(!bus.Mem_OE && !bus.Mem_WE), 32'd0);
    if (!bus.Mem_OE) oe_lo++;
    if (!bus.Mem_WE) we_lo++;
    if (bus.Drive_En) de_cnt++;
    if (bus.CPU_Ack || bus.LDR_Ack) begin
      ack_total++;
      check("single_ack", 32'(bus.CPU_Ack && bus.LDR_Ack), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_who", 32'(bus.LDR_Ack), 32'(e.who));
        check("ack_rdata", 32'(bus.Rdata), 32'(e.rdata));
        if (e.lat != 0) check("ack_latency", 32'(cyc - e.issue), 32'(e.lat));
        if (e.gap != 0) check("ack_gap", 32'(cyc - last_ack), 32'(e.gap));
      end
      last_ack = cyc;
    end
  end

  task automatic wait_acks(int target, string name);
    int n = 0;
    forever begin
      @(posedge clk);
      n++;
      if (ack_total >= target || n >= 40) break;
    end
    #1;
    check(name, 32'(ack_total >= target), 32'd1);
  endtask

  task automatic set_cpu(logic req, logic we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    bus.CPU_Req = req; bus.CPU_WE = we; bus.CPU_Addr = a; bus.CPU_Wdata = d;
  endtask

  task automatic set_ldr(logic req, logic we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    bus.LDR_Req = req; bus.LDR_WE = we; bus.LDR_Addr = a; bus.LDR_Wdata = d;
  endtask

  task automatic clear_counts();
    oe_lo = 0; we_lo = 0; de_cnt = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'h1234;
    mem[8'h30] = 16'h3333;
    mem[8'h40] = 16'h4444;
    mem[8'h50] = 16'h5555;
    rst = 1'b1;
    set_cpu(1'b0, 1'b0, 20'h0, 16'h0);
    set_ldr(1'b0, 1'b0, 20'h0, 16'h0);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ack", 32'(bus.CPU_Ack), 32'd0);
    check("rst_ldr_ack", 32'(bus.LDR_Ack), 32'd0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_drive_en", 32'(bus.Drive_En), 32'd0);
    check("rst_mem_oe", 32'(bus.Mem_OE), 32'd1);
    check("rst_mem_we", 32'(bus.Mem_WE), 32'd1);
    check("rst_addr", 32'(bus.ADDR), 32'd0);
    check("rst_rdata", 32'(bus.Rdata), 32'd0);
    check("rst_wdata", 32'(bus.Data_to_SRAM), 32'd0);
    check("rst_ce", 32'({bus.Mem_CE, bus.Mem_UB, bus.Mem_LB}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // CPU read of 0x00010
    clear_counts();
    push(WHO_CPU, 16'h1234, 3, 0);
    set_cpu(1'b1, 1'b0, 20'h00010, 16'h0);
    wait_acks(1, "t1_timeout");
    bus.CPU_Req = 1'b0;
    check("t1_oe_cycles", 32'(oe_lo), 32'd2);
    check("t1_we_cycles", 32'(we_lo), 32'd0);

    // Loader write 0xBEEF to 0x00020, Rdata keeps the previous read
    clear_counts();
    push(WHO_LDR, 16'h1234, 3, 0);
    set_ldr(1'b1, 1'b1, 20'h00020, 16'hBEEF);
    wait_acks(2, "t2w_timeout");
    bus.LDR_Req = 1'b0;
    check("t2_we_cycles", 32'(we_lo), 32'd2);
    check("t2_drive_cycles", 32'(de_cnt), 32'd2);
    check("t2_oe_cycles", 32'(oe_lo), 32'd0);
    check("t2_mem_written", 32'(mem[8'h20]), 32'hBEEF);
    // CPU reads it back
    push(WHO_CPU, 16'hBEEF, 3, 0);
    set_cpu(1'b1, 1'b0, 20'h00020, 16'h0);
    wait_acks(3, "t2r_timeout");
    bus.CPU_Req = 1'b0;

    // Continuous contention right after reset: CPU, LDR, CPU, LDR
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    push(WHO_CPU, 16'h1234, 3, 0);
    push(WHO_LDR, 16'hBEEF, 0, 4);
    push(WHO_CPU, 16'h1234, 0, 4);
    push(WHO_LDR, 16'hBEEF, 0, 4);
    set_cpu(1'b1, 1'b0, 20'h00010, 16'h0);
    set_ldr(1'b1, 1'b0, 20'h00020, 16'h0);
    wait_acks(7, "t3_timeout");
    bus.CPU_Req = 1'b0;
    bus.LDR_Req = 1'b0;

    // Address change after grant is ignored
    push(WHO_CPU, 16'h3333, 3, 0);
    set_cpu(1'b1, 1'b0, 20'h00030, 16'h0);
    @(posedge clk); #1;
    bus.CPU_Addr = 20'h00040;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_addr_held", 32'(bus.ADDR), 32'h00030);
    end
    wait_acks(8, "t4_timeout");
    bus.CPU_Req = 1'b0;

    // Reset during Acc2 of a read drops the access
    set_cpu(1'b1, 1'b0, 20'h00050, 16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.CPU_Req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_busy", 32'(bus.Busy), 32'd0);
    check("t5_rdata", 32'(bus.Rdata), 32'd0);
    check("t5_mem_oe", 32'(bus.Mem_OE), 32'd1);
    check("t5_cpu_ack", 32'(bus.CPU_Ack), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_ack", 32'(ack_total), 32'd8);
    push(WHO_CPU, 16'h1234, 3, 0);
    push(WHO_LDR, 16'hBEEF, 0, 4);
    set_cpu(1'b1, 1'b0, 20'h00010, 16'h0);
    set_ldr(1'b1, 1'b0, 20'h00020, 16'h0);
    wait_acks(10, "t5_timeout");
    bus.CPU_Req = 1'b0;
    bus.LDR_Req = 1'b0;

    // CPU holds Req through Ack: back-to-back accesses 4 cycles apart
    push(WHO_CPU, 16'h1234, 3, 0);
    push(WHO_CPU, 16'h1234, 0, 4);
    set_cpu(1'b1, 1'b0, 20'h00010, 16'h0);
    wait_acks(12, "t6_timeout");
    bus.CPU_Req = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
